// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared coefficient types and widths for the NTT bank datapath
package ntt_pkg;

  localparam int NTT_DATA_W = 32;
  localparam int NTT_ADDR_W = 8;

  typedef logic [NTT_DATA_W-1:0] coef_t;
  typedef logic [NTT_ADDR_W-1:0] coef_addr_t;

  typedef struct packed {
    coef_addr_t addr;
    coef_t      data;
  } bank_word_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ntt_sync_fifo.sv
// rtl/ntt_sync_fifo.sv - small synchronous FIFO with pointer/count bookkeeping
module ntt_sync_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ntt_bank_demux.sv
// rtl/ntt_bank_demux.sv - 1-to-2 coefficient router into two bank write FIFOs
// Optional DEMUX_STATS_EN adds stall and per-bank pop counters.
module ntt_bank_demux
  import ntt_pkg::*;
#(
  parameter int DATA_W        = NTT_DATA_W,
  parameter int ADDR_W        = NTT_ADDR_W,
  parameter int DEPTH         = 2,
  parameter int ROUTE_BY_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              sel,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic [ADDR_W-1:0] out0_addr,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [ADDR_W-1:0] out1_addr,
  output logic              busy
`ifdef DEMUX_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       out0_cnt,
  output logic [15:0]       out1_cnt
`endif
);

  localparam int WORD_W = ADDR_W + DATA_W;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic              tgt;
  logic [WORD_W-1:0] in_word, head0, head1;
  logic              full0, full1, empty0, empty1;
  logic [CNT_W-1:0]  cnt0, cnt1;
  logic              push0, push1, pop0, pop1;

  assign tgt      = (ROUTE_BY_ADDR != 0) ? in_addr[0] : sel;
  // Ready looks only at registered fullness, never at the bank readies.
  assign in_ready = tgt ? !full1 : !full0;
  assign in_word  = {in_addr, in_data};
  assign push0    = in_valid && in_ready && !tgt;
  assign push1    = in_valid && in_ready && tgt;

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;
  assign pop0       = out0_valid && out0_ready;
  assign pop1       = out1_valid && out1_ready;
  assign {out0_addr, out0_data} = head0;
  assign {out1_addr, out1_data} = head1;
  assign busy = (|cnt0) || (|cnt1);

  ntt_sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .wdata (in_word),
    .pop   (pop0),
    .rdata (head0),
    .full  (full0),
    .empty (empty0),
    .count (cnt0)
  );

  ntt_sync_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .wdata (in_word),
    .pop   (pop1),
    .rdata (head1),
    .full  (full1),
    .empty (empty1),
    .count (cnt1)
  );

`ifdef DEMUX_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] out0_cnt_q, out0_cnt_d;
  logic [15:0] out1_cnt_q, out1_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    out0_cnt_d  = out0_cnt_q;
    out1_cnt_d  = out1_cnt_q;
    if (in_valid && !in_ready) stall_cnt_d = sat_inc16(stall_cnt_q);
    if (pop0)                  out0_cnt_d  = sat_inc16(out0_cnt_q);
    if (pop1)                  out1_cnt_d  = sat_inc16(out1_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      out0_cnt_q  <= '0;
      out1_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      out0_cnt_q  <= out0_cnt_d;
      out1_cnt_q  <= out1_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign out0_cnt  = out0_cnt_q;
  assign out1_cnt  = out1_cnt_q;
`endif

endmodule

// File: tb/tb_ntt_bank_demux.sv
// tb/tb_ntt_bank_demux.sv - scoreboard bench for ntt_bank_demux (sel and address routing)
module tb_ntt_bank_demux;
  import ntt_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_in_valid, s_sel, s_o0_ready, s_o1_ready;
  logic [7:0]  s_in_addr;
  logic [31:0] s_in_data;
  logic        s_in_ready, s_o0_valid, s_o1_valid, s_busy;
  logic [31:0] s_o0_data, s_o1_data;
  logic [7:0]  s_o0_addr, s_o1_addr;

  logic        a_in_valid, a_sel, a_o0_ready, a_o1_ready;
  logic [7:0]  a_in_addr;
  logic [31:0] a_in_data;
  logic        a_in_ready, a_o0_valid, a_o1_valid, a_busy;
  logic [31:0] a_o0_data, a_o1_data;
  logic [7:0]  a_o0_addr, a_o1_addr;

`ifdef DEMUX_STATS_EN
  logic [15:0] s_stall_cnt, s_out0_cnt, s_out1_cnt;
  logic [15:0] a_stall_cnt, a_out0_cnt, a_out1_cnt;
`endif

  ntt_bank_demux #(.ROUTE_BY_ADDR(0)) dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_addr(s_in_addr), .sel(s_sel),
    .out0_valid(s_o0_valid), .out0_ready(s_o0_ready), .out0_data(s_o0_data), .out0_addr(s_o0_addr),
    .out1_valid(s_o1_valid), .out1_ready(s_o1_ready), .out1_data(s_o1_data), .out1_addr(s_o1_addr),
    .busy(s_busy)
`ifdef DEMUX_STATS_EN
    , .stall_cnt(s_stall_cnt), .out0_cnt(s_out0_cnt), .out1_cnt(s_out1_cnt)
`endif
  );

  ntt_bank_demux #(.ROUTE_BY_ADDR(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_addr(a_in_addr), .sel(a_sel),
    .out0_valid(a_o0_valid), .out0_ready(a_o0_ready), .out0_data(a_o0_data), .out0_addr(a_o0_addr),
    .out1_valid(a_o1_valid), .out1_ready(a_o1_ready), .out1_data(a_o1_data), .out1_addr(a_o1_addr),
    .busy(a_busy)
`ifdef DEMUX_STATS_EN
    , .stall_cnt(a_stall_cnt), .out0_cnt(a_out0_cnt), .out1_cnt(a_out1_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  // Expected queues: 0/1 = sel-routed banks, 2/3 = address-routed banks.
  bank_word_t exp_q [4][$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_out(input int idx, input logic v, input logic r, input bank_word_t got);
    bank_word_t e;
    if (v && r) begin
      checks++;
      if (exp_q[idx].size() == 0) begin
        errors++;
        $display("FAIL out%0d_unexpected: got addr %0h data %0h expected no word", idx, got.addr, got.data);
      end else begin
        e = exp_q[idx].pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out%0d_word: got addr %0h data %0h expected addr %0h data %0h",
                   idx, got.addr, got.data, e.addr, e.data);
        end
      end
    end
  endtask

  // Monitor samples just before each rising edge, when pops actually happen.
  always @(negedge clk) begin
    #4;
    if (rst_n === 1'b1) begin
      check_out(0, s_o0_valid, s_o0_ready, {s_o0_addr, s_o0_data});
      check_out(1, s_o1_valid, s_o1_ready, {s_o1_addr, s_o1_data});
      check_out(2, a_o0_valid, a_o0_ready, {a_o0_addr, a_o0_data});
      check_out(3, a_o1_valid, a_o1_ready, {a_o1_addr, a_o1_data});
    end
  end

  task automatic send(input int which, input logic s, input logic [7:0] a,
                      input logic [31:0] d, output int stalls);
    logic rdy;
    bit   done;
    int   idx;
    stalls = 0;
    done   = 0;
    if (which == 0) begin
      s_in_valid = 1'b1; s_sel = s; s_in_addr = a; s_in_data = d;
    end else begin
      a_in_valid = 1'b1; a_sel = s; a_in_addr = a; a_in_data = d;
    end
    while (!done) begin
      #1;
      rdy = (which == 0) ? s_in_ready : a_in_ready;
      @(posedge clk);
      if (rdy) begin
        idx = (which == 0) ? (s ? 1 : 0) : (a[0] ? 3 : 2);
        exp_q[idx].push_back({a, d});
        done = 1;
      end else begin
        stalls++;
        if (stalls > 20) begin
          checks++;
          errors++;
          $display("FAIL send_timeout: got no accept expected accept within 20 cycles");
          s_in_valid = 1'b0;
          a_in_valid = 1'b0;
          done = 1;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((s_busy || a_busy || exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
            exp_q[2].size() != 0 || exp_q[3].size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 30), 32'd1);
  endtask

  initial begin
    int st;
    rst_n = 1'b0;
    s_in_valid = 0; s_sel = 0; s_in_addr = 0; s_in_data = 0; s_o0_ready = 1; s_o1_ready = 1;
    a_in_valid = 0; a_sel = 0; a_in_addr = 0; a_in_data = 0; a_o0_ready = 1; a_o1_ready = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out0_valid", s_o0_valid, 0);
    chk("rst_out1_valid", s_o1_valid, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_in_ready", s_in_ready, 1);
    chk("rst_a_in_ready", a_in_ready, 1);
`ifdef DEMUX_STATS_EN
    chk("rst_stall_cnt", s_stall_cnt, 0);
    chk("rst_out0_cnt", s_out0_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sel routing with one-cycle visibility.
    send(0, 1'b0, 8'h10, 32'd5, st);
    chk("basic_stall0", st, 0);
    #1;
    chk("basic_out0_valid", s_o0_valid, 1);
    chk("basic_out0_data", s_o0_data, 32'd5);
    send(0, 1'b1, 8'h11, 32'd10, st);
    s_in_valid = 1'b0;
    #1;
    chk("basic_out1_valid", s_o1_valid, 1);
    chk("basic_out1_data", s_o1_data, 32'd10);
    @(negedge clk);

    // Mid-stream asynchronous reset with two words queued in bank 0.
    s_o0_ready = 1'b0;
    send(0, 1'b0, 8'h30, 32'hAA, st);
    send(0, 1'b0, 8'h31, 32'hBB, st);
    s_in_valid = 1'b0;
    #1;
    chk("mid_busy_before", s_busy, 1);
    chk("mid_full_ready", s_in_ready, 0);
    #1;
    rst_n = 1'b0;
    exp_q[0].delete();
    #1;
    chk("mid_rst_out0_valid", s_o0_valid, 0);
    chk("mid_rst_busy", s_busy, 0);
    chk("mid_rst_in_ready", s_in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    s_o0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("no_stale_out0", s_o0_valid, 0);
      @(negedge clk);
    end

    // Backpressure on bank 0, bank 1 stays open.
    s_o0_ready = 1'b0;
    send(0, 1'b0, 8'h20, 32'd1, st);
    chk("bp_w1_stall", st, 0);
    send(0, 1'b0, 8'h21, 32'd2, st);
    chk("bp_w2_stall", st, 0);
    send(0, 1'b1, 8'h40, 32'd7, st);
    chk("indep_stall", st, 0);
    #1;
    chk("indep_out1_valid", s_o1_valid, 1);
    chk("indep_out1_data", s_o1_data, 32'd7);
    s_sel = 1'b0; s_in_addr = 8'h22; s_in_data = 32'd3;
    #1;
    chk("bp_w3_ready_low", s_in_ready, 0);
    repeat (3) @(negedge clk);
    s_o0_ready = 1'b1;
    send(0, 1'b0, 8'h22, 32'd3, st);
    chk("bp_no_pop_bypass", st, 1);
    s_in_valid = 1'b0;
    wait_drain("bp_drain");
`ifdef DEMUX_STATS_EN
    chk("stats_stall_cnt", s_stall_cnt, 4);
    chk("stats_out0_cnt", s_out0_cnt, 3);
    chk("stats_out1_cnt", s_out1_cnt, 1);
`endif

    // Address interleave: sel deliberately opposes the address parity.
    for (int i = 0; i < 8; i++) begin
      send(1, (i % 2 == 0), 8'(i), 32'(i * 2), st);
      chk("addr_stall", st, 0);
    end
    a_in_valid = 1'b0;
    wait_drain("addr_drain");

    chk("final_q0_empty", exp_q[0].size(), 0);
    chk("final_q1_empty", exp_q[1].size(), 0);
    chk("final_q2_empty", exp_q[2].size(), 0);
    chk("final_q3_empty", exp_q[3].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
